// File: rtl/shift_reg4.sv
// shift_reg4: fixed-latency serial-in/serial-out delay line.
// Optional SHIFTREG4_VALID_EN adds a dout_valid fill flag.
module shift_reg4 #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
`ifdef SHIFTREG4_VALID_EN
  output logic dout_valid,
`endif
  output logic dout
);

  logic [DEPTH-1:0] stage;

  // Shift one stage toward dout on every edge; reset clears the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage <= {stage[DEPTH-2:0], din};
    end
  end

  assign dout = stage[DEPTH-1];

`ifdef SHIFTREG4_VALID_EN
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  logic [FW-1:0] fill;
  logic [FW-1:0] fill_nxt;

  // Saturating count of edges seen since reset.
  always_comb begin
    fill_nxt = fill;
    if (fill != FULL) begin
      fill_nxt = fill + FW'(1);
    end
  end

  // Flag goes high on the edge that brings the first real bit to dout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill       <= '0;
      dout_valid <= 1'b0;
    end else begin
      fill       <= fill_nxt;
      dout_valid <= (fill_nxt == FULL);
    end
  end
`endif

endmodule

// File: tb/tb_shift_reg4.sv
// tb_shift_reg4: vectors, corner sequences and random
// stimulus against a sample-history model.
module tb_shift_reg4;

  logic clk;
  logic rst;
  logic din;
  logic dout4;
  logic dout8;
`ifdef SHIFTREG4_VALID_EN
  logic valid4;
  logic valid8;
`endif

  int checks = 0;
  int errors = 0;

  shift_reg4 #(.DEPTH(4)) u_dut4 (
    .clk(clk),
    .rst(rst),
    .din(din),
`ifdef SHIFTREG4_VALID_EN
    .dout_valid(valid4),
`endif
    .dout(dout4)
  );

  shift_reg4 #(.DEPTH(8)) u_dut8 (
    .clk(clk),
    .rst(rst),
    .din(din),
`ifdef SHIFTREG4_VALID_EN
    .dout_valid(valid8),
`endif
    .dout(dout8)
  );

  initial begin
    clk = 1'b0;
    forever #15 clk = ~clk;
  end

  // Reference: every bit captured since the last reset.
  bit hist[$];

  always @(posedge rst) hist.delete();

  always @(posedge clk) begin
    if (!rst) hist.push_back(din);
  end

  function automatic logic exp_out(int d);
    if (hist.size() >= d) return hist[hist.size() - d];
    return 1'b0;
  endfunction

  function automatic logic exp_valid(int d);
    return hist.size() >= d;
  endfunction

  task automatic chk(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(string nm);
    chk({nm, "_d4"}, dout4, exp_out(4));
    chk({nm, "_d8"}, dout8, exp_out(8));
`ifdef SHIFTREG4_VALID_EN
    chk({nm, "_v4"}, valid4, exp_valid(4));
    chk({nm, "_v8"}, valid8, exp_valid(8));
`endif
  endtask

  typedef struct {
    logic din;
    logic exp;
  } vec_t;

  vec_t tbl[11];

  int hi_cnt;
  int hi_at;

  initial begin
    tbl[0]  = '{1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0};

    rst = 1'b0;
    din = 1'b1;

    // Reset acts without a clock edge.
    #10 rst = 1'b1;
    #1;
    chk("rst_async_d4", dout4, 1'b0);
    chk("rst_async_d8", dout8, 1'b0);
`ifdef SHIFTREG4_VALID_EN
    chk("rst_async_v4", valid4, 1'b0);
`endif
    @(posedge clk);
    #1;
    chk("rst_edge15_d4", dout4, 1'b0);
    #14 rst = 1'b0;

    // Latency/pattern vectors, starting at the 45 ns edge.
    for (int i = 0; i < 11; i++) begin
      din = tbl[i].din;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d", i), dout4, tbl[i].exp);
`ifdef SHIFTREG4_VALID_EN
      chk($sformatf("vec%0d_v", i), valid4, (i >= 3));
`endif
      chk_model($sformatf("vec%0d_m", i));
    end

    // Fill with ones, then reset between edges.
    din = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("ones_d4", dout4, 1'b1);
    #5 rst = 1'b1;
    #1;
    chk("mid_rst_d4", dout4, 1'b0);
    chk("mid_rst_d8", dout8, 1'b0);
`ifdef SHIFTREG4_VALID_EN
    chk("mid_rst_v4", valid4, 1'b0);
`endif
    #4 rst = 1'b0;
    din = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("post_rst%0d", i), dout4, 1'b0);
`ifdef SHIFTREG4_VALID_EN
      chk($sformatf("post_rst%0d_v", i), valid4, (i == 3));
`endif
    end

    // Single pulse through the 8-deep line.
    din = 1'b1;
    hi_cnt = 0;
    hi_at = -1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      din = 1'b0;
      if (dout8 === 1'b1) begin
        hi_cnt++;
        if (hi_at < 0) hi_at = e;
      end
      chk_model($sformatf("pulse%0d", e));
    end
    chk("pulse8_count", (hi_cnt == 1), 1'b1);
    chk("pulse8_edge", (hi_at == 8), 1'b1);

    // din toggles every 12 ns, never on a rising edge.
    fork
      begin
        repeat (17) #12 din = ~din;
      end
      begin
        repeat (7) begin
          @(negedge clk);
          chk_model("toggle");
        end
      end
    join

    // Random bits with occasional reset pulses between edges.
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      chk_model("rnd");
      din = 1'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        #5 rst = 1'b1;
        #1;
        chk_model("rnd_rst");
        #4 rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
